framebuf_arbiter: RTL and testbench

//   Shares one single-port frame-buffer SRAM between the camera capture path (writes) and the
//   VGA scan-out path (reads). VGA reads are real-time and always win; camera writes are

---
 rtl/framebuf_arbiter.sv | 117 +++++++++++
 tb/tb_framebuf_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuf_arbiter.sv
// Frame-buffer SRAM arbiter: VGA reads always win, camera writes
// queue in a FIFO and drain into read-free cycles.
module framebuf_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int WBUF_DEPTH = 1024,
  parameter int MEM_LAT    = 1
) (
  input  logic                              iCLK,
  input  logic                              iRST,
  input  logic                              iWR_REQ,
  input  logic [ADDR_W-1:0]                 iWR_ADDR,
  input  logic [DATA_W-1:0]                 iWR_DATA,
  output logic                              oWR_ACK,
  output logic                              oWR_FULL,
  output logic [$clog2(WBUF_DEPTH+1)-1:0]   oWR_LEVEL,
  output logic                              oWR_OVF,
  input  logic                              iOVF_CLR,
  input  logic                              iRD_REQ,
  input  logic [ADDR_W-1:0]                 iRD_ADDR,
  output logic [DATA_W-1:0]                 oRD_DATA,
  output logic                              oRD_VALID,
  output logic [ADDR_W-1:0]                 oMEM_ADDR,
  output logic [DATA_W-1:0]                 oMEM_WDATA,
  output logic                              oMEM_WE,
  output logic                              oMEM_CE,
  input  logic [DATA_W-1:0]                 iMEM_RDATA
);

  localparam int PTR_W  = $clog2(WBUF_DEPTH);
  localparam int LVL_W  = $clog2(WBUF_DEPTH+1);
  localparam int PIPE_W = MEM_LAT + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(WBUF_DEPTH);

  // State bits are {CE, WE} so the SRAM strobes come straight off flops.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b10,
    S_WR   = 2'b11
  } state_t;

  state_t state, nxt;

  logic [ADDR_W+DATA_W-1:0] fifo [WBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level, level_nxt;
  logic              full, ovf;
  logic              push, pop, empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [PIPE_W-1:0] rd_pipe;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  assign empty = (level == '0);
  assign push  = iWR_REQ & ~full;
  assign pop   = (nxt == S_WR);
  assign {head_addr, head_data} = fifo[rd_ptr];
  assign level_nxt = level + LVL_W'(push) - LVL_W'(pop);

  assign oWR_ACK    = push;
  assign oWR_FULL   = full;
  assign oWR_LEVEL  = level;
  assign oWR_OVF    = ovf;
  assign {oMEM_CE, oMEM_WE} = state;
  assign oMEM_ADDR  = mem_addr;
  assign oMEM_WDATA = mem_wdata;
  assign oRD_VALID  = rd_valid;
  assign oRD_DATA   = rd_data;

  always_comb begin
    nxt = S_IDLE;
    if (iRD_REQ)     nxt = S_RD;
    else if (!empty) nxt = S_WR;
  end

  always_ff @(posedge iCLK) begin
    if (push) fifo[wr_ptr] <= {iWR_ADDR, iWR_DATA};
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      full      <= 1'b0;
      ovf       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_pipe   <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      state <= nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
      full  <= (level_nxt == DEPTH_L);
      // A drop in the same cycle as a clear keeps the flag set.
      if (iWR_REQ && full) ovf <= 1'b1;
      else if (iOVF_CLR)   ovf <= 1'b0;
      if (nxt == S_RD) begin
        mem_addr <= iRD_ADDR;
      end else if (nxt == S_WR) begin
        mem_addr  <= head_addr;
        mem_wdata <= head_data;
      end
      rd_pipe  <= (rd_pipe << 1) | PIPE_W'(iRD_REQ);
      rd_valid <= rd_pipe[PIPE_W-1];
      if (rd_pipe[PIPE_W-1]) rd_data <= iMEM_RDATA;
    end
  end

endmodule

// File: tb/tb_framebuf_arbiter.sv
// Scoreboard bench for framebuf_arbiter with an SRAM model and
// a reference memory built from accepted camera writes.
module tb_framebuf_arbiter;

  localparam int AW = 19;
  localparam int DW = 16;
  localparam int DEPTH = 1024;
  localparam int LW = 11;
  localparam int RD_LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack, wr_full, wr_ovf;
  logic [LW-1:0] wr_level;
  logic          ovf_clr = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, mem_ce;
  logic [DW-1:0] mem_rdata = '0;

  framebuf_arbiter dut (
    .iCLK(clk), .iRST(rst),
    .iWR_REQ(wr_req), .iWR_ADDR(wr_addr), .iWR_DATA(wr_data),
    .oWR_ACK(wr_ack), .oWR_FULL(wr_full), .oWR_LEVEL(wr_level),
    .oWR_OVF(wr_ovf), .iOVF_CLR(ovf_clr),
    .iRD_REQ(rd_req), .iRD_ADDR(rd_addr),
    .oRD_DATA(rd_data), .oRD_VALID(rd_valid),
    .oMEM_ADDR(mem_addr), .oMEM_WDATA(mem_wdata),
    .oMEM_WE(mem_we), .oMEM_CE(mem_ce), .iMEM_RDATA(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  rd_exp_t       rq[$];
  wr_t           wq[$];
  logic [DW-1:0] refm [logic [AW-1:0]];
  logic [DW-1:0] sram [logic [AW-1:0]];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            we_cnt = 0;

  // Preloaded picture in never-written SRAM space.
  function automatic logic [DW-1:0] bg(logic [AW-1:0] a);
    if (a == 19'h04B00) return 16'h1234;
    return a[15:0] ^ 16'h5A5A ^ {13'd0, a[18:16]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_ce && mem_we) sram[mem_addr] = mem_wdata;
    else if (mem_ce)
      mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : bg(mem_addr);
  end

  wr_t     mw;
  rd_exp_t me;

  always @(negedge clk) begin
    if (rst) begin
      rq.delete();
      wq.delete();
      refm.delete();
    end else begin
      if (wr_req && wr_ack) begin
        mw.addr = wr_addr;
        mw.data = wr_data;
        wq.push_back(mw);
        refm[wr_addr] = wr_data;
      end
      if (mem_we) begin
        we_cnt++;
        chk("we_without_ce", {31'd0, mem_ce}, 1);
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: addr %0h data %0h", mem_addr, mem_wdata);
        end else begin
          mw = wq.pop_front();
          chk("wr_addr", {13'd0, mem_addr}, {13'd0, mw.addr});
          chk("wr_data", {16'd0, mem_wdata}, {16'd0, mw.data});
        end
      end
      if (rd_valid) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: data %0h at cycle %0d", rd_data, cyc);
        end else begin
          me = rq.pop_front();
          chk("rd_data", {16'd0, rd_data}, {16'd0, me.data});
          chk("rd_cycle", cyc, me.due);
        end
      end
      while (rq.size() > 0 && rq[0].due < cyc) begin
        me = rq.pop_front();
        checks++;
        errors++;
        $display("FAIL rd_missing: due %0d now %0d", me.due, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic rd, logic [AW-1:0] ra,
                       logic wr, logic [AW-1:0] wa, logic [DW-1:0] wd);
    rd_exp_t e;
    rd_req  = rd;
    rd_addr = ra;
    wr_req  = wr;
    wr_addr = wa;
    wr_data = wd;
    if (rd && !rst) begin
      e.data = bg(ra);
      e.due  = cyc + RD_LAT;
      rq.push_back(e);
    end
  endtask

  function automatic logic [AW-1:0] rnd_raddr();
    return AW'($urandom_range(32'h100, 32'h3FFFF));
  endfunction

  task automatic check_reset_state(string tag);
    chk({tag, "_full"},   {31'd0, wr_full}, 0);
    chk({tag, "_level"},  {21'd0, wr_level}, 0);
    chk({tag, "_ovf"},    {31'd0, wr_ovf}, 0);
    chk({tag, "_rvalid"}, {31'd0, rd_valid}, 0);
    chk({tag, "_rdata"},  {16'd0, rd_data}, 0);
    chk({tag, "_maddr"},  {13'd0, mem_addr}, 0);
    chk({tag, "_mwdata"}, {16'd0, mem_wdata}, 0);
    chk({tag, "_mwe"},    {31'd0, mem_we}, 0);
    chk({tag, "_mce"},    {31'd0, mem_ce}, 0);
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (wr_level == 0) break;
      n++;
    end
    chk(name, {21'd0, wr_level}, 0);
    tick();
    tick();
  endtask

  task automatic compare_sram(string name);
    foreach (refm[a])
      chk(name, {16'd0, sram.exists(a) ? sram[a] : bg(a)}, {16'd0, refm[a]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wb;
    // power-on reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("por");

    // single write drains into a free cycle
    tick();
    drive(0, '0, 1, 19'h00010, 16'hABCD);
    @(negedge clk);
    chk("t2_ack", {31'd0, wr_ack}, 1);
    tick();
    drive(0, '0, 0, '0, '0);
    @(negedge clk);
    chk("t2_level1", {21'd0, wr_level}, 1);
    tick();
    @(negedge clk);
    chk("t2_we",    {31'd0, mem_we}, 1);
    chk("t2_addr",  {13'd0, mem_addr}, 32'h10);
    chk("t2_wdata", {16'd0, mem_wdata}, 32'hABCD);
    chk("t2_level0", {21'd0, wr_level}, 0);

    // read latency
    tick();
    drive(1, 19'h04B00, 0, '0, '0);
    tick();
    drive(0, '0, 0, '0, '0);
    @(negedge clk);
    chk("t3_ce",   {31'd0, mem_ce}, 1);
    chk("t3_we",   {31'd0, mem_we}, 0);
    chk("t3_addr", {13'd0, mem_addr}, 32'h04B00);
    tick();
    tick();
    @(negedge clk);
    chk("t3_valid", {31'd0, rd_valid}, 1);
    chk("t3_data",  {16'd0, rd_data}, 32'h1234);
    repeat (3) tick();

    // read burst starves queued writes
    wb = we_cnt;
    for (int i = 0; i < 640; i++) begin
      tick();
      drive(1, rnd_raddr(), i < 8, 19'h40100 + AW'(i), DW'($urandom));
    end
    tick();
    drive(0, '0, 0, '0, '0);
    @(negedge clk);
    chk("t4_level8", {21'd0, wr_level}, 8);
    tick();
    chk("t4_burst_we", we_cnt - wb, 0);
    repeat (8) tick();
    chk("t4_drain_we", we_cnt - wb, 8);
    @(negedge clk);
    chk("t4_level0", {21'd0, wr_level}, 0);

    // fill, overflow, sticky flag
    for (int k = 0; k <= DEPTH; k++) begin
      tick();
      drive(1, rnd_raddr(), 1, 19'h41000 + AW'(k), DW'($urandom));
      if (k == DEPTH - 1) begin
        @(negedge clk);
        chk("t5_nfull", {31'd0, wr_full}, 0);
        chk("t5_ack_last", {31'd0, wr_ack}, 1);
      end
      if (k == DEPTH) begin
        @(negedge clk);
        chk("t5_full", {31'd0, wr_full}, 1);
        chk("t5_drop_ack", {31'd0, wr_ack}, 0);
        chk("t5_level_max", {21'd0, wr_level}, DEPTH);
      end
    end
    tick();
    drive(1, rnd_raddr(), 1, 19'h7FFFF, 16'hDEAD);
    ovf_clr = 1'b1;
    @(negedge clk);
    chk("t5_ovf", {31'd0, wr_ovf}, 1);
    chk("t5_level_hold", {21'd0, wr_level}, DEPTH);
    tick();
    drive(1, rnd_raddr(), 0, '0, '0);
    @(negedge clk);
    chk("t5_set_wins", {31'd0, wr_ovf}, 1);
    tick();
    ovf_clr = 1'b0;
    drive(1, rnd_raddr(), 0, '0, '0);
    @(negedge clk);
    chk("t5_ovf_clr", {31'd0, wr_ovf}, 0);
    tick();
    drive(0, '0, 0, '0, '0);
    wait_drain("t5_drain");
    compare_sram("t5_sram");

    // reset in the middle of traffic
    for (int i = 0; i < 50; i++) begin
      tick();
      drive(1, rnd_raddr(), $urandom_range(0, 1) == 1,
            19'h42000 + AW'(i), DW'($urandom));
    end
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    drive(0, '0, 0, '0, '0);
    @(negedge clk);
    check_reset_state("t1");
    repeat (6) tick();

    // VGA-like timing with random camera writes, two frames
    for (int f = 0; f < 2; f++) begin
      for (int v = 0; v < 26; v++) begin
        for (int h = 0; h < 100; h++) begin
          tick();
          drive(v < 20 && h < 64, 19'h100 + AW'(v * 64 + h),
                $urandom_range(0, 99) < 30,
                19'h40000 + AW'($urandom_range(0, 255)), DW'($urandom));
        end
      end
      tick();
      drive(0, '0, 0, '0, '0);
      wait_drain("t6_drain");
      compare_sram("t6_sram");
    end
    @(negedge clk);
    chk("t6_no_ovf", {31'd0, wr_ovf}, 0);
    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
